fetch_pc_ifid: RTL and testbench

- Front of the pipeline: owns the program counter and the IF/ID pipeline register.
- Drives the word address into the combinational instruction ROM and captures the returned instruction word, with its PC, into IF/ID for decode.
- Handles stall from hazard detection and redirect/flush from the execute stage (taken branch/jump).

---
 rtl/fetch_pc_ifid_if.sv | 31 +++
 rtl/fetch_pc_ifid.sv | 85 ++++++++
 tb/tb_fetch_pc_ifid.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pc_ifid_if.sv
// Bus between the fetch stage and its neighbours: hazard/redirect controls in,
// ROM address/data, and the IF/ID register contents out to decode.
interface fetch_pc_ifid_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     stall;
  logic                     flush;
  logic                     redirect_en;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic [ADDRESS_WIDTH-1:0] instr_addr;
  logic [DATA_WIDTH-1:0]    instr;
  logic [DATA_WIDTH-1:0]    id_instr;
  logic [ADDRESS_WIDTH-1:0] id_pc;
  logic [ADDRESS_WIDTH-1:0] id_pc_plus4;
  logic                     id_valid;
  logic                     misalign_err;
  logic [31:0]              fetch_count;

  modport master (
    input  stall, flush, redirect_en, redirect_target, instr,
    output instr_addr, id_instr, id_pc, id_pc_plus4, id_valid,
           misalign_err, fetch_count
  );

  modport slave (
    output stall, flush, redirect_en, redirect_target, instr,
    input  instr_addr, id_instr, id_pc, id_pc_plus4, id_valid,
           misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_pc_ifid.sv
// PC register plus IF/ID pipeline register; 1-cycle fetch latency from PC to IF/ID.
// Stall holds PC and IF/ID; redirect/flush insert a bubble (redirect costs one).
module fetch_pc_ifid #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_ifid_if.master bus
);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    id_instr_q, id_instr_d;
  logic [ADDRESS_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [ADDRESS_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic                     id_valid_q, id_valid_d;
  logic                     misalign_q, misalign_d;
  logic [31:0]              fetch_count_q, fetch_count_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     load_ifid;

  assign pc_plus4  = pc_q + ADDRESS_WIDTH'(4);
  assign load_ifid = !bus.flush && !bus.redirect_en && !bus.stall;

  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = misalign_q | (bus.redirect_en && (bus.redirect_target[1:0] != 2'b00));

    // Redirect overrides stall so a taken branch never gets lost behind a hazard.
    if (bus.redirect_en) begin
      pc_d = {bus.redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (!bus.stall) begin
      pc_d = pc_plus4;
    end

    if (bus.flush || bus.redirect_en) begin
      id_instr_d    = NOP_INSTR;
      id_pc_d       = '0;
      id_pc_plus4_d = '0;
      id_valid_d    = 1'b0;
    end else if (load_ifid) begin
      id_instr_d    = bus.instr;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.instr_addr   = pc_q;
  assign bus.id_instr     = id_instr_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_pc_plus4  = id_pc_plus4_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Directed bench for fetch_pc_ifid: inputs driven and outputs sampled on the
// falling edge, with a 64-word ROM indexed by instr_addr[7:2].
module tb_fetch_pc_ifid;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] rom [64];

  always #5 clk = ~clk;

  fetch_pc_ifid_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_pc_ifid #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.instr = rom[bus.instr_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic vld);
    chk({tag, ".id_pc"},       bus.id_pc,       pc);
    chk({tag, ".id_instr"},    bus.id_instr,    ins);
    chk({tag, ".id_pc_plus4"}, bus.id_pc_plus4, pc4);
    chk({tag, ".id_valid"},    {31'd0, bus.id_valid}, {31'd0, vld});
  endtask

  task automatic edge_n;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_en = 1'b0;
    bus.redirect_target = '0;

    edge_n; edge_n;
    chk("rst.addr", bus.instr_addr, 32'h0);
    chk_id("rst", 32'h0, NOP, 32'h0, 1'b0);
    chk("rst.misalign", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst.count", bus.fetch_count, 32'd0);
    rst = 1'b0;
    #1 chk("pre_edge.valid", {31'd0, bus.id_valid}, 32'd0);

    edge_n; chk_id("f0", 32'h0, 32'h11, 32'h4, 1'b1); chk("f0.addr", bus.instr_addr, 32'h4);
    edge_n; chk_id("f1", 32'h4, 32'h22, 32'h8, 1'b1); chk("f1.addr", bus.instr_addr, 32'h8);

    bus.stall = 1'b1;
    edge_n; chk("st1.addr", bus.instr_addr, 32'h8); chk_id("st1", 32'h4, 32'h22, 32'h8, 1'b1);
    chk("st1.count", bus.fetch_count, 32'd2);
    edge_n; chk("st2.addr", bus.instr_addr, 32'h8); chk_id("st2", 32'h4, 32'h22, 32'h8, 1'b1);
    chk("st2.count", bus.fetch_count, 32'd2);
    bus.stall = 1'b0;
    edge_n; chk_id("f2", 32'h8, 32'h33, 32'hC, 1'b1); chk("f2.count", bus.fetch_count, 32'd3);
    chk("f2.addr", bus.instr_addr, 32'hC);

    bus.redirect_en = 1'b1; bus.redirect_target = 32'h40;
    edge_n; chk("rd.addr", bus.instr_addr, 32'h40); chk_id("rd", 32'h0, NOP, 32'h0, 1'b0);
    chk("rd.count", bus.fetch_count, 32'd3);
    bus.redirect_en = 1'b0;
    edge_n; chk_id("rd_tgt", 32'h40, 32'hA000_0010, 32'h44, 1'b1);
    chk("rd_tgt.count", bus.fetch_count, 32'd4); chk("rd_tgt.addr", bus.instr_addr, 32'h44);

    bus.stall = 1'b1; bus.flush = 1'b1; bus.redirect_en = 1'b1; bus.redirect_target = 32'h20;
    edge_n; chk("all.addr", bus.instr_addr, 32'h20); chk_id("all", 32'h0, NOP, 32'h0, 1'b0);
    chk("all.count", bus.fetch_count, 32'd4);
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_en = 1'b0;
    edge_n; chk_id("all_tgt", 32'h20, 32'hA000_0008, 32'h24, 1'b1);
    chk("all_tgt.count", bus.fetch_count, 32'd5);
    chk("pre_mis.misalign", {31'd0, bus.misalign_err}, 32'd0);

    bus.redirect_en = 1'b1; bus.redirect_target = 32'h23;
    edge_n; chk("mis.addr", bus.instr_addr, 32'h20);
    chk("mis.misalign", {31'd0, bus.misalign_err}, 32'd1);
    bus.redirect_en = 1'b0;
    edge_n; chk_id("mis1", 32'h20, 32'hA000_0008, 32'h24, 1'b1);
    chk("mis1.misalign", {31'd0, bus.misalign_err}, 32'd1);
    edge_n; chk_id("mis2", 32'h24, 32'hA000_0009, 32'h28, 1'b1);
    chk("mis2.misalign", {31'd0, bus.misalign_err}, 32'd1);
    chk("mis2.count", bus.fetch_count, 32'd7);

    bus.flush = 1'b1;
    edge_n; chk("fl.addr", bus.instr_addr, 32'h2C); chk_id("fl", 32'h0, NOP, 32'h0, 1'b0);
    chk("fl.count", bus.fetch_count, 32'd7);
    bus.flush = 1'b0;
    edge_n; chk_id("fl1", 32'h2C, 32'hA000_000B, 32'h30, 1'b1);
    chk("fl1.count", bus.fetch_count, 32'd8);

    bus.redirect_en = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    edge_n; chk("top.addr", bus.instr_addr, 32'hFFFF_FFFC);
    bus.redirect_en = 1'b0;
    edge_n; chk("wrap.addr", bus.instr_addr, 32'h0);
    chk_id("wrap", 32'hFFFF_FFFC, 32'hA000_003F, 32'h0, 1'b1);
    chk("wrap.count", bus.fetch_count, 32'd9);

    // Reset lands mid-cycle with stall and redirect active; check before the next edge.
    bus.stall = 1'b1; bus.redirect_en = 1'b1; bus.redirect_target = 32'h80;
    #2 rst = 1'b1;
    #1;
    chk("arst.addr", bus.instr_addr, 32'h0);
    chk_id("arst", 32'h0, NOP, 32'h0, 1'b0);
    chk("arst.misalign", {31'd0, bus.misalign_err}, 32'd0);
    chk("arst.count", bus.fetch_count, 32'd0);
    edge_n;
    rst = 1'b0; bus.stall = 1'b0; bus.redirect_en = 1'b0;
    edge_n; chk_id("post_rst", 32'h0, 32'h11, 32'h4, 1'b1);
    chk("post_rst.addr", bus.instr_addr, 32'h4);
    chk("post_rst.count", bus.fetch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
